// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage with register file, write-first bypass, load-use stall and ID/EX register
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int CTRL_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidD,
    input  logic [31:0]           InstrD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [CTRL_WIDTH-1:0] CtrlD,
    input  logic                  UsesRs1D,
    input  logic                  UsesRs2D,
    input  logic                  LoadD,
    input  logic                  RegWriteW,
    input  logic [4:0]            RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  FlushE,
    output logic                  StallD,
    output logic                  ValidE,
    output logic                  LoadE,
    output logic [CTRL_WIDTH-1:0] CtrlE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic [4:0]            RdE,
    output logic [2:0]            funct3E,
    output logic [CNT_WIDTH-1:0]  StallCount,
    output logic [DATA_WIDTH-1:0] a0
);
    // Always 32 entries so any 5-bit index is legal; entries at or above NUM_REGS are never written or read.
    logic [DATA_WIDTH-1:0] regs [32];
    logic [4:0] rs1, rs2;
    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic hazard, bubble, wr_en, unused;

    function automatic logic in_file(input logic [4:0] r);
        return r != 5'd0 && 32'(r) < NUM_REGS;
    endfunction

    always_comb begin
        rs1 = InstrD[19:15];
        rs2 = InstrD[24:20];
        wr_en = RegWriteW && in_file(RdW);
        rd1 = !in_file(rs1) ? '0 : (wr_en && RdW == rs1) ? ResultW : regs[rs1];
        rd2 = !in_file(rs2) ? '0 : (wr_en && RdW == rs2) ? ResultW : regs[rs2];
        hazard = ValidD && ValidE && LoadE && RdE != 5'd0 &&
                 ((UsesRs1D && rs1 == RdE) || (UsesRs2D && rs2 == RdE));
        StallD = hazard && !FlushE;
        bubble = FlushE || StallD || !ValidD;
        a0 = regs[10];
        unused = ^{InstrD[31:25], InstrD[6:0]};
    end

    always_ff @(posedge clk)
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            StallCount <= '0;
        end else begin
            if (wr_en) regs[RdW] <= ResultW;
            if (StallD && StallCount != '1) StallCount <= StallCount + 1'b1;
        end

    // Bubbles zero every field, not just ValidE, so E-stage contents are deterministic.
    always_ff @(posedge clk)
        if (rst || bubble) begin
            ValidE   <= 1'b0;
            LoadE    <= 1'b0;
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            funct3E  <= '0;
        end else begin
            ValidE   <= 1'b1;
            LoadE    <= LoadD;
            CtrlE    <= CtrlD;
            RD1E     <= rd1;
            RD2E     <= rd2;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= rs1;
            Rs2E     <= rs2;
            RdE      <= InstrD[11:7];
            funct3E  <= InstrD[14:12];
        end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: RV32I/16-bit-counter and RV32E/2-bit-counter instances against a behavioural model
module tb_id_ex_stage;
    logic clk = 0, rst = 0;
    logic valid_d, u1, u2, ld, wb, flush;
    logic [31:0] instr, pc, pc4, imm, resw;
    logic [11:0] ctrl;
    logic [4:0] rdw;

    logic stall_a, valid_a, load_a, stall_b, valid_b, load_b;
    logic [11:0] ctrl_a, ctrl_b;
    logic [31:0] rd1_a, rd2_a, imm_a, pc_a, pc4_a, a0_a, rd1_b, rd2_b, imm_b, pc_b, pc4_b, a0_b;
    logic [4:0] rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;
    logic [2:0] f3_a, f3_b;
    logic [15:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    id_ex_stage dut_a (
        .clk(clk), .rst(rst), .ValidD(valid_d), .InstrD(instr), .PCD(pc), .PCPlus4D(pc4),
        .ImmExtD(imm), .CtrlD(ctrl), .UsesRs1D(u1), .UsesRs2D(u2), .LoadD(ld),
        .RegWriteW(wb), .RdW(rdw), .ResultW(resw), .FlushE(flush), .StallD(stall_a),
        .ValidE(valid_a), .LoadE(load_a), .CtrlE(ctrl_a), .RD1E(rd1_a), .RD2E(rd2_a),
        .ImmExtE(imm_a), .PCE(pc_a), .PCPlus4E(pc4_a), .Rs1E(rs1_a), .Rs2E(rs2_a),
        .RdE(rd_a), .funct3E(f3_a), .StallCount(cnt_a), .a0(a0_a)
    );

    id_ex_stage #(.NUM_REGS(16), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .ValidD(valid_d), .InstrD(instr), .PCD(pc), .PCPlus4D(pc4),
        .ImmExtD(imm), .CtrlD(ctrl), .UsesRs1D(u1), .UsesRs2D(u2), .LoadD(ld),
        .RegWriteW(wb), .RdW(rdw), .ResultW(resw), .FlushE(flush), .StallD(stall_b),
        .ValidE(valid_b), .LoadE(load_b), .CtrlE(ctrl_b), .RD1E(rd1_b), .RD2E(rd2_b),
        .ImmExtE(imm_b), .PCE(pc_b), .PCPlus4E(pc4_b), .Rs1E(rs1_b), .Rs2E(rs2_b),
        .RdE(rd_b), .funct3E(f3_b), .StallCount(cnt_b), .a0(a0_b)
    );

    typedef struct packed {
        logic valid, load;
        logic [11:0] ctrl;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
    } est_t;

    est_t me [2];
    logic [31:0] mr [2][32];
    int mcnt [2];
    int nregs [2] = '{32, 16};
    int cmax [2] = '{65535, 3};
    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input int k, input logic [4:0] r);
        if (r == 0 || int'(r) >= nregs[k]) return 0;
        if (wb && rdw == r) return resw;
        return mr[k][r];
    endfunction

    function automatic logic mhaz(input int k);
        return valid_d && me[k].valid && me[k].load && me[k].rd != 0 &&
               ((u1 && instr[19:15] == me[k].rd) || (u2 && instr[24:20] == me[k].rd));
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            me[k] = '0;
            mcnt[k] = 0;
            for (int r = 0; r < 32; r++) mr[k][r] = 0;
        end
    endtask

    task automatic check_all();
        chk("A.valid", valid_a, me[0].valid);  chk("B.valid", valid_b, me[1].valid);
        chk("A.load", load_a, me[0].load);     chk("B.load", load_b, me[1].load);
        chk("A.ctrl", ctrl_a, me[0].ctrl);     chk("B.ctrl", ctrl_b, me[1].ctrl);
        chk("A.rd1", rd1_a, me[0].rd1);        chk("B.rd1", rd1_b, me[1].rd1);
        chk("A.rd2", rd2_a, me[0].rd2);        chk("B.rd2", rd2_b, me[1].rd2);
        chk("A.imm", imm_a, me[0].imm);        chk("B.imm", imm_b, me[1].imm);
        chk("A.pc", pc_a, me[0].pc);           chk("B.pc", pc_b, me[1].pc);
        chk("A.pc4", pc4_a, me[0].pc4);        chk("B.pc4", pc4_b, me[1].pc4);
        chk("A.rs1", rs1_a, me[0].rs1);        chk("B.rs1", rs1_b, me[1].rs1);
        chk("A.rs2", rs2_a, me[0].rs2);        chk("B.rs2", rs2_b, me[1].rs2);
        chk("A.rd", rd_a, me[0].rd);           chk("B.rd", rd_b, me[1].rd);
        chk("A.f3", f3_a, me[0].f3);           chk("B.f3", f3_b, me[1].f3);
        chk("A.cnt", cnt_a, mcnt[0]);          chk("B.cnt", cnt_b, mcnt[1]);
        chk("A.a0", a0_a, mr[0][10]);          chk("B.a0", a0_b, mr[1][10]);
    endtask

    task automatic step();
        est_t nx [2];
        logic sd [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sd[k] = mhaz(k) && !flush;
            if (rst || flush || sd[k] || !valid_d) nx[k] = '0;
            else nx[k] = '{1'b1, ld, ctrl, mread(k, instr[19:15]), mread(k, instr[24:20]), imm, pc, pc4,
                           instr[19:15], instr[24:20], instr[11:7], instr[14:12]};
        end
        chk("A.stall", stall_a, sd[0]);
        chk("B.stall", stall_b, sd[1]);
        @(posedge clk);
        #1;
        if (rst) mreset();
        else for (int k = 0; k < 2; k++) begin
            me[k] = nx[k];
            if (wb && rdw != 0 && int'(rdw) < nregs[k]) mr[k][rdw] = resw;
            if (sd[k] && mcnt[k] < cmax[k]) mcnt[k]++;
        end
        check_all();
    endtask

    task automatic dec(input logic v, input logic [31:0] i, input logic a1, input logic a2, input logic l);
        valid_d = v; instr = i; u1 = a1; u2 = a2; ld = l;
        pc = pc + 4; pc4 = pc + 4; imm = $urandom; ctrl = 12'($urandom);
    endtask

    function automatic logic [4:0] ridx();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        valid_d = 0; instr = 0; u1 = 0; u2 = 0; ld = 0; wb = 0; flush = 0;
        pc = 32'h1000; pc4 = 0; imm = 0; resw = 0; ctrl = 0; rdw = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        mreset();
        check_all();
        step();
        rst = 0;
        // Fresh register file reads zero.
        dec(1, 32'h00028093, 1, 0, 0);
        step();
        chk("rst_x5_rd1", rd1_a, 32'h0);
        // Same-cycle writeback is bypassed into decode.
        wb = 1; rdw = 3; resw = 32'hDEADBEEF;
        dec(1, 32'h00118213, 1, 0, 0);
        imm = 1;
        step();
        chk("bypass_rd1", rd1_a, 32'hDEADBEEF);
        chk("bypass_valid", valid_a, 1'b1);
        // Writeback to x0 is neither stored nor bypassed.
        rdw = 0; resw = 32'hFF;
        dec(1, 32'h00000093, 1, 0, 0);
        step();
        chk("x0_rd1", rd1_a, 32'h0);
        wb = 0;
        // Load-use from a clean counter.
        rst = 1; step(); rst = 0;
        dec(1, 32'h0000A303, 1, 0, 1);
        step();
        chk("lu_loadE", load_a, 1'b1);
        chk("lu_rdE", rd_a, 5'd6);
        dec(1, 32'h002303B3, 1, 1, 0);
        step();
        chk("lu_bubble", valid_a, 1'b0);
        step();
        chk("lu_issue_rd", rd_a, 5'd7);
        chk("lu_issue_valid", valid_a, 1'b1);
        chk("lu_cnt", cnt_a, 16'd1);
        // Flush beats the hazard: no stall, no count.
        dec(1, 32'h0000A303, 1, 0, 1);
        step();
        dec(1, 32'h002303B3, 1, 1, 0);
        flush = 1;
        step();
        flush = 0;
        chk("flush_bubble", valid_a, 1'b0);
        chk("flush_cnt", cnt_a, 16'd1);
        // RV32E drops x20 writes; x10 appears on a0 next cycle.
        dec(0, 32'h0, 0, 0, 0);
        wb = 1; rdw = 20; resw = 32'h55;
        step();
        rdw = 10; resw = 32'h1234;
        step();
        chk("rv32e_a0", a0_b, 32'h1234);
        wb = 0;
        dec(1, 32'h000A0093, 1, 0, 0);
        step();
        chk("rv32e_x20", rd1_b, 32'h0);
        chk("rv32i_x20", rd1_a, 32'h55);
        // Two-bit counter saturates after three stalls.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            dec(1, 32'h0000A303, 1, 0, 1);
            step();
            dec(1, 32'h002303B3, 1, 1, 0);
            step();
            chk("sat_cnt", cnt_b, (i < 3) ? 2'(i + 1) : 2'd3);
        end
        // Randomised traffic with small register indices to provoke hazards and bypasses.
        repeat (400) begin
            dec($urandom_range(0, 9) != 0, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
            instr[19:15] = ridx();
            instr[24:20] = ridx();
            instr[11:7] = ridx();
            pc = $urandom; pc4 = $urandom;
            flush = $urandom_range(0, 9) == 0;
            wb = 1'($urandom);
            rdw = ridx();
            resw = $urandom;
            rst = $urandom_range(0, 99) == 0;
            step();
        end
        rst = 0; flush = 0; wb = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
